// File: rtl/slc3_regfile_sb.sv
// slc3_regfile_sb
//   NREGS x WIDTH register file with two combinational read ports, one write
//   port and write-through bypass. It also holds the NZP condition codes, the
//   branch-enable flag and a per-register busy scoreboard. The scoreboard
//   raises STALL while a source operand is reserved by an in-flight
//   multi-cycle op.
//
// Optional feature macro: SLC3_RF_R0_ZERO_EN
//   defined   : R0 is hardwired to zero. Writes to R0 are discarded, the
//               bypass to R0 is disabled, R0 is never busy and reserving R0
//               is ignored.
//   undefined : R0 is an ordinary register (default).
//
// Ports
//   Clk, Reset        rising-edge clock, asynchronous active-high reset
//   LD_REG, DR, D_In  write port; D_In also feeds the CC logic
//   SR1, SR2          read addresses     -> SR1_OUT, SR2_OUT
//   USE_SR1, USE_SR2  stall qualifiers   -> STALL
//   RSV_EN, RSV_DR    reserve a register -> BUSY, RSV_ERR (sticky)
//   LD_CC             load CC {N,Z,P} from D_In -> CC
//   LD_BEN, IR_NZP    load BEN = |(IR_NZP & CC) -> BEN
module slc3_regfile_sb #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_REG,
  input  logic [AW-1:0]    DR,
  input  logic [WIDTH-1:0] D_In,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  input  logic             USE_SR1,
  input  logic             USE_SR2,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  input  logic             RSV_EN,
  input  logic [AW-1:0]    RSV_DR,
  output logic             STALL,
  output logic [NREGS-1:0] BUSY,
  output logic             RSV_ERR,
  input  logic             LD_CC,
  output logic [2:0]       CC,
  input  logic             LD_BEN,
  input  logic [2:0]       IR_NZP,
  output logic             BEN
);

`ifdef SLC3_RF_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_rsv_err;
  logic [2:0]       r_cc;
  logic             r_ben;

  logic             w_wr_en;     // write that actually lands (R0 discarded when zeroed)
  logic             w_rsv_v;     // reservation that actually takes effect
  logic             w_byp1;
  logic             w_byp2;
  logic             w_err_set;
  logic [NREGS-1:0] w_busy_n;
  logic [2:0]       w_cc_n;

  assign w_wr_en = LD_REG & ~(R0Z & (DR == '0));
  assign w_rsv_v = RSV_EN & ~(R0Z & (RSV_DR == '0));

  // Bypass: a write landing this cycle is visible on the read ports now.
  assign w_byp1 = w_wr_en & (DR == SR1);
  assign w_byp2 = w_wr_en & (DR == SR2);

  always_comb begin
    SR1_OUT = w_byp1 ? D_In : r_regs[SR1];
    SR2_OUT = w_byp2 ? D_In : r_regs[SR2];
    if (R0Z && (SR1 == '0)) SR1_OUT = '0;
    if (R0Z && (SR2 == '0)) SR2_OUT = '0;
  end

  // A source being written this cycle is satisfied by the bypass.
  assign STALL = (USE_SR1 & r_busy[SR1] & ~w_byp1) |
                 (USE_SR2 & r_busy[SR2] & ~w_byp2);

  // Set wins over clear so a reserve+write in the same cycle leaves the
  // register busy for the new in-flight result.
  always_comb begin
    w_busy_n = r_busy;
    for (int i = 0; i < NREGS; i++) begin
      if (w_wr_en && (DR == AW'(i)))     w_busy_n[i] = 1'b0;
      if (w_rsv_v && (RSV_DR == AW'(i))) w_busy_n[i] = 1'b1;
    end
  end

  // Double reservation is only an error if the pending result is not being
  // retired in the same cycle.
  assign w_err_set = w_rsv_v & r_busy[RSV_DR] & ~(w_wr_en & (DR == RSV_DR));

  always_comb begin
    if (D_In == '0)          w_cc_n = 3'b010;
    else if (D_In[WIDTH-1])  w_cc_n = 3'b100;
    else                     w_cc_n = 3'b001;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy    <= '0;
      r_rsv_err <= 1'b0;
      r_cc      <= 3'b010;
      r_ben     <= 1'b0;
    end else begin
      if (w_wr_en) r_regs[DR] <= D_In;
      r_busy    <= w_busy_n;
      r_rsv_err <= r_rsv_err | w_err_set;
      if (LD_CC)  r_cc  <= w_cc_n;
      // Uses the registered CC, so LD_CC in the same cycle is not seen.
      if (LD_BEN) r_ben <= |(IR_NZP & r_cc);
    end
  end

  assign BUSY    = r_busy;
  assign RSV_ERR = r_rsv_err;
  assign CC      = r_cc;
  assign BEN     = r_ben;

endmodule

// File: tb/tb_slc3_regfile_sb.sv
module tb_slc3_regfile_sb;

`ifdef SLC3_RF_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        LD_REG = 1'b0;
  logic [2:0]  DR = '0;
  logic [15:0] D_In = '0;
  logic [2:0]  SR1 = '0;
  logic [2:0]  SR2 = '0;
  logic        USE_SR1 = 1'b0;
  logic        USE_SR2 = 1'b0;
  logic [15:0] SR1_OUT;
  logic [15:0] SR2_OUT;
  logic        RSV_EN = 1'b0;
  logic [2:0]  RSV_DR = '0;
  logic        STALL;
  logic [7:0]  BUSY;
  logic        RSV_ERR;
  logic        LD_CC = 1'b0;
  logic [2:0]  CC;
  logic        LD_BEN = 1'b0;
  logic [2:0]  IR_NZP = '0;
  logic        BEN;

  slc3_regfile_sb #(.WIDTH(16), .NREGS(8)) dut (
    .Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .D_In(D_In),
    .SR1(SR1), .SR2(SR2), .USE_SR1(USE_SR1), .USE_SR2(USE_SR2),
    .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .RSV_EN(RSV_EN), .RSV_DR(RSV_DR),
    .STALL(STALL), .BUSY(BUSY), .RSV_ERR(RSV_ERR), .LD_CC(LD_CC), .CC(CC),
    .LD_BEN(LD_BEN), .IR_NZP(IR_NZP), .BEN(BEN)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: architectural state
  logic [15:0] m_regs [8];
  logic [7:0]  m_busy;
  logic        m_err;
  logic [2:0]  m_cc;
  logic        m_ben;

  function automatic bit lands(input logic [2:0] a);
    return !(R0Z && a == 3'd0);
  endfunction

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (R0Z && a == 3'd0) return 16'h0000;
    if (LD_REG && lands(DR) && DR == a) return D_In;
    return m_regs[a];
  endfunction

  function automatic logic exp_stall();
    logic s;
    s = 1'b0;
    if (USE_SR1 && m_busy[SR1] && !(LD_REG && lands(DR) && DR == SR1)) s = 1'b1;
    if (USE_SR2 && m_busy[SR2] && !(LD_REG && lands(DR) && DR == SR2)) s = 1'b1;
    return s;
  endfunction

  function automatic logic [2:0] cc_of(input logic [15:0] d);
    if (d == 16'h0000) return 3'b010;
    if (d[15])         return 3'b100;
    return 3'b001;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
      m_busy <= 8'h00;
      m_err  <= 1'b0;
      m_cc   <= 3'b010;
      m_ben  <= 1'b0;
    end else begin
      if (RSV_EN && lands(RSV_DR) && m_busy[RSV_DR] &&
          !(LD_REG && lands(DR) && DR == RSV_DR)) m_err <= 1'b1;
      if (LD_REG && lands(DR)) begin
        m_regs[DR] <= D_In;
        m_busy[DR] <= 1'b0;
      end
      // later assignment wins: reservation overrides the retiring write
      if (RSV_EN && lands(RSV_DR)) m_busy[RSV_DR] <= 1'b1;
      if (LD_BEN) m_ben <= |(IR_NZP & m_cc);
      if (LD_CC)  m_cc  <= cc_of(D_In);
    end
  end

  // compare process: every falling edge once the model is initialised
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("sr1_out", SR1_OUT, exp_rd(SR1));
      chk("sr2_out", SR2_OUT, exp_rd(SR2));
      chk("stall",   STALL,   exp_stall());
      chk("busy",    BUSY,    m_busy);
      chk("rsv_err", RSV_ERR, m_err);
      chk("cc",      CC,      m_cc);
      chk("ben",     BEN,     m_ben);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    LD_REG = 0; RSV_EN = 0; LD_CC = 0; LD_BEN = 0; USE_SR1 = 0; USE_SR2 = 0;
  endtask

  task automatic rand_cycle();
    LD_REG  = ($urandom_range(0, 2) == 0);
    DR      = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0:       D_In = 16'h0000;
      1:       D_In = 16'h8000 | 16'($urandom_range(0, 32767));
      default: D_In = 16'($urandom_range(0, 65535));
    endcase
    SR1     = 3'($urandom_range(0, 7));
    SR2     = ($urandom_range(0, 3) == 0) ? SR1 : 3'($urandom_range(0, 7));
    USE_SR1 = 1'($urandom_range(0, 1));
    USE_SR2 = 1'($urandom_range(0, 1));
    RSV_EN  = ($urandom_range(0, 4) == 0);
    RSV_DR  = ($urandom_range(0, 3) == 0) ? DR : 3'($urandom_range(0, 7));
    LD_CC   = 1'($urandom_range(0, 1));
    LD_BEN  = 1'($urandom_range(0, 1));
    IR_NZP  = 3'($urandom_range(0, 7));
    step();
  endtask

  initial begin
    step(); step();
    Reset = 0;
    chk_en = 1'b1;
    #2;
    chk("rst_cc", CC, 3'b010);
    chk("rst_busy", BUSY, 8'h00);
    chk("rst_ben", BEN, 1'b0);
    chk("rst_err", RSV_ERR, 1'b0);
    chk("rst_reg", SR1_OUT, 16'h0000);

    // write then read; same-cycle bypass
    LD_REG = 1; DR = 3; D_In = 16'h1234;
    step();
    LD_REG = 0; SR1 = 3;
    #2 chk("rd_r3", SR1_OUT, 16'h1234);
    LD_REG = 1; DR = 5; D_In = 16'hBEEF; SR2 = 5;
    #1 chk("bypass_r5", SR2_OUT, 16'hBEEF);
    step();
    idle();

    // condition codes and BEN ordering
    LD_CC = 1; D_In = 16'h8000; step(); #2 chk("cc_neg", CC, 3'b100);
    D_In = 16'h0000; step(); #2 chk("cc_zero", CC, 3'b010);
    D_In = 16'h0001; step(); #2 chk("cc_pos", CC, 3'b001);
    D_In = 16'h0000; LD_BEN = 1; IR_NZP = 3'b010;
    step(); #2 chk("ben_old_cc", BEN, 1'b0);
    LD_CC = 0;
    step(); #2 chk("ben_new_cc", BEN, 1'b1);
    idle();

    // reservation, stall, retire
    RSV_EN = 1; RSV_DR = 2;
    step();
    RSV_EN = 0; USE_SR1 = 1; SR1 = 2;
    #2 chk("stall_set", STALL, 1'b1);
    chk("busy_r2", BUSY, 8'h04);
    LD_REG = 1; DR = 2; D_In = 16'h00AA;
    #1 chk("stall_retire", STALL, 1'b0);
    step();
    idle();
    #2 chk("busy_clr", BUSY, 8'h00);

    // set wins over clear; double reservation error is sticky
    RSV_EN = 1; RSV_DR = 4; LD_REG = 1; DR = 4; D_In = 16'h0444;
    step();
    LD_REG = 0;
    #2 chk("set_wins", BUSY, 8'h10);
    chk("no_err", RSV_ERR, 1'b0);
    step();
    RSV_EN = 0;
    #2 chk("err_set", RSV_ERR, 1'b1);
    step(); step();
    chk("err_held", RSV_ERR, 1'b1);

    // randomized phase
    for (int i = 0; i < 600; i++) rand_cycle();
    idle();
    step();

    // async reset aborts reservations mid-cycle
    RSV_EN = 1; RSV_DR = 1; step();
    RSV_DR = 6; step();
    RSV_EN = 0; USE_SR1 = 1; SR1 = 1; USE_SR2 = 1; SR2 = 6;
    #1 chk("pre_rst_stall", STALL, 1'b1);
    Reset = 1;
    #1;
    chk("arst_busy", BUSY, 8'h00);
    chk("arst_cc", CC, 3'b010);
    chk("arst_stall", STALL, 1'b0);
    chk("arst_err", RSV_ERR, 1'b0);
    step();
    Reset = 0;
    idle();
    step();

`ifdef SLC3_RF_R0_ZERO_EN
    LD_REG = 1; DR = 0; D_In = 16'hFFFF; SR1 = 0;
    #1 chk("r0_bypass", SR1_OUT, 16'h0000);
    step();
    LD_REG = 0;
    #1 chk("r0_read", SR1_OUT, 16'h0000);
    RSV_EN = 1; RSV_DR = 0;
    step();
    RSV_EN = 0;
    #1 chk("r0_busy", BUSY, 8'h00);
    chk("r0_err", RSV_ERR, 1'b0);
    step();
`endif

    for (int i = 0; i < 200; i++) rand_cycle();
    idle();
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
